mc_fetch_unit: RTL and testbench

Program-counter and non-architectural register stage of the multicycle MIPS core, directly downstream of the main control FSM. It holds PC, Instruction Register (IR), Memory Data Register (MDR) and ALUOut. It consumes the FSM's `pcwrite`, `branch`, `irwrite`, `iord` and `pcsrc` strobes and produces the memory address. It returns the decoded instruction fields, including `op`, which feeds back into the FSM. A retired-instruction counter is included for bring-up and performance measurement.

---
 rtl/mc_pkg.sv | 24 ++
 rtl/mc_fetch_unit_flopenr.sv | 20 ++
 rtl/mc_fetch_unit.sv | 98 +++++++++
 tb/tb_mc_fetch_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS core: next-PC source encoding,
// opcode constants and the immediate sign-extension helper.
package mc_pkg;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_RSVD   = 2'b11
  } pcsrc_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  // Sign-extend a 16-bit immediate to a full data word.
  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mc_fetch_unit_flopenr.sv
// Enable flop with asynchronous active-high reset to a parameterised value.
module flopenr #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Register d when enabled; reset forces RESET_VAL without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (reset)   q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mc_fetch_unit.sv
// PC / IR / MDR / ALUOut stage of the multicycle MIPS core with instruction
// field decode and a retired-instruction counter.
module mc_fetch_unit
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pcwrite,
  input  logic                 branch,
  input  logic                 zero,
  input  logic                 irwrite,
  input  logic                 iord,
  input  logic [1:0]           pcsrc,
  input  logic [31:0]          aluresult,
  input  logic [31:0]          readdata,
  output logic [31:0]          adr,
  output logic [31:0]          pc,
  output logic [31:0]          instr,
  output logic [31:0]          data,
  output logic [31:0]          aluout,
  output logic [5:0]           op,
  output logic [5:0]           funct,
  output logic [4:0]           rs,
  output logic [4:0]           rt,
  output logic [4:0]           rd,
  output logic [31:0]          signimm,
  output logic [CNT_WIDTH-1:0] retired
);

  logic                 pcen;
  pcsrc_t               pcsrc_sel;
  logic [31:0]          pc_d, pc_q;
  logic [31:0]          instr_q, data_q, aluout_q;
  logic [CNT_WIDTH-1:0] retired_d, retired_q;

  assign pcsrc_sel = pcsrc_t'(pcsrc);
  assign pcen      = pcwrite | (branch & zero);

  // Next-PC select; the jump target is built from the already-incremented PC.
  always_comb begin
    // NOTE: default assigned first so no path leaves pc_d unassigned (no latch).
    pc_d = pc_q;
    case (pcsrc_sel)
      PCSRC_ALU:    pc_d = aluresult;
      PCSRC_ALUOUT: pc_d = aluout_q;
      PCSRC_JUMP:   pc_d = {pc_q[31:28], instr_q[25:0], 2'b00};
      PCSRC_RSVD:   pc_d = pc_q;
      default:      pc_d = pc_q;
    endcase
  end

  flopenr #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .en(pcen), .d(pc_d), .q(pc_q)
  );

  flopenr #(.WIDTH(32), .RESET_VAL(32'h0)) u_ir (
    .clk(clk), .reset(reset), .en(irwrite), .d(readdata), .q(instr_q)
  );

  flopenr #(.WIDTH(32), .RESET_VAL(32'h0)) u_mdr (
    .clk(clk), .reset(reset), .en(1'b1), .d(readdata), .q(data_q)
  );

  flopenr #(.WIDTH(32), .RESET_VAL(32'h0)) u_aluout (
    .clk(clk), .reset(reset), .en(1'b1), .d(aluresult), .q(aluout_q)
  );

  // Retired count advances once per IR load and wraps silently.
  always_comb begin
    retired_d = retired_q;
    if (irwrite) retired_d = retired_q + CNT_WIDTH'(1);
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign adr     = iord ? aluout_q : pc_q;
  assign pc      = pc_q;
  assign instr   = instr_q;
  assign data    = data_q;
  assign aluout  = aluout_q;
  assign retired = retired_q;

  // Field decode always comes from the IR, never straight from memory.
  assign op      = instr_q[31:26];
  assign rs      = instr_q[25:21];
  assign rt      = instr_q[20:16];
  assign rd      = instr_q[15:11];
  assign funct   = instr_q[5:0];
  assign signimm = sign_ext16(instr_q[15:0]);

endmodule

// File: tb/tb_mc_fetch_unit.sv
// Self-checking bench for mc_fetch_unit: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_mc_fetch_unit;

  localparam logic [31:0] RESET_PC_W = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcwrite, branch, zero, irwrite, iord;
  logic [1:0]  pcsrc;
  logic [31:0] aluresult, readdata;

  logic [31:0] adr, pc, instr, data, aluout, signimm;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] retired;

  logic [31:0] adr_w, pc_w, instr_w, data_w, aluout_w, signimm_w;
  logic [5:0]  op_w, funct_w;
  logic [4:0]  rs_w, rt_w, rd_w;
  logic [3:0]  retired_w;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  logic [31:0] m_pc, m_ir, m_mdr, m_alu;
  int unsigned m_ret;

  mc_fetch_unit dut (
    .clk(clk), .reset(reset), .pcwrite(pcwrite), .branch(branch), .zero(zero),
    .irwrite(irwrite), .iord(iord), .pcsrc(pcsrc), .aluresult(aluresult),
    .readdata(readdata), .adr(adr), .pc(pc), .instr(instr), .data(data),
    .aluout(aluout), .op(op), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
    .signimm(signimm), .retired(retired)
  );

  // Narrow-counter, non-zero reset PC instance to reach wrap and the parameter.
  mc_fetch_unit #(.RESET_PC(RESET_PC_W), .CNT_WIDTH(4)) dut_w (
    .clk(clk), .reset(reset), .pcwrite(pcwrite), .branch(branch), .zero(zero),
    .irwrite(irwrite), .iord(iord), .pcsrc(pcsrc), .aluresult(aluresult),
    .readdata(readdata), .adr(adr_w), .pc(pc_w), .instr(instr_w), .data(data_w),
    .aluout(aluout_w), .op(op_w), .funct(funct_w), .rs(rs_w), .rt(rt_w), .rd(rd_w),
    .signimm(signimm_w), .retired(retired_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ir = 32'h0; m_mdr = 32'h0; m_alu = 32'h0; m_ret = 0;
  endtask

  task automatic set_in(input logic pw, input logic br, input logic z, input logic ir,
                        input logic io, input logic [1:0] src,
                        input logic [31:0] alu, input logic [31:0] rdat);
    pcwrite = pw; branch = br; zero = z; irwrite = ir; iord = io; pcsrc = src;
    aluresult = alu; readdata = rdat;
  endtask

  // One clock: model next state from spec rules, then sample #1 after the edge.
  task automatic step();
    logic [31:0] npc;
    logic        en;
    en = pcwrite || (branch && zero);
    case (pcsrc)
      2'd0:    npc = aluresult;
      2'd1:    npc = m_alu;
      2'd2:    npc = {m_pc[31:28], m_ir[25:0], 2'b00};
      default: npc = m_pc;
    endcase
    @(posedge clk);
    if (en) m_pc = npc;
    if (irwrite) begin
      m_ir  = readdata;
      m_ret = m_ret + 1;
    end
    m_mdr = readdata;
    m_alu = aluresult;
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},      pc,      m_pc);
    check({tag, ".instr"},   instr,   m_ir);
    check({tag, ".data"},    data,    m_mdr);
    check({tag, ".aluout"},  aluout,  m_alu);
    check({tag, ".adr"},     adr,     iord ? m_alu : m_pc);
    check({tag, ".op"},      {26'b0, op},    {26'b0, m_ir[31:26]});
    check({tag, ".funct"},   {26'b0, funct}, {26'b0, m_ir[5:0]});
    check({tag, ".rs"},      {27'b0, rs},    {27'b0, m_ir[25:21]});
    check({tag, ".rt"},      {27'b0, rt},    {27'b0, m_ir[20:16]});
    check({tag, ".rd"},      {27'b0, rd},    {27'b0, m_ir[15:11]});
    check({tag, ".signimm"}, signimm, {{16{m_ir[15]}}, m_ir[15:0]});
    check({tag, ".retired"}, retired, m_ret);
    check({tag, ".retired_w"}, {28'b0, retired_w}, m_ret % 16);
  endtask

  typedef struct {
    logic        pw, br, z, ir;
    logic [1:0]  src;
    logic [31:0] alu, rdat;
    logic [31:0] exp_pc, exp_instr, exp_aluout;
    int unsigned exp_ret;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // Directed table, starting from reset (PC = 0).
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h4,         32'h2008_0005, 32'h4,         32'h2008_0005, 32'h4,         1};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h40,        32'h0,         32'h4,         32'h2008_0005, 32'h40,        1};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 32'h99,        32'h0,         32'h40,        32'h2008_0005, 32'h99,        1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 32'h44,        32'h0,         32'h40,        32'h2008_0005, 32'h44,        1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 32'h1234,      32'h0,         32'h40,        32'h2008_0005, 32'h1234,      1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h1000_0004, 32'h0,         32'h1000_0004, 32'h2008_0005, 32'h1000_0004, 1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,         32'h0800_0010, 32'h1000_0004, 32'h0800_0010, 32'h0,         2};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0,         32'h0,         32'h1000_0040, 32'h0800_0010, 32'h0,         2};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h5,         32'h8C09_FFFC, 32'h1000_0040, 32'h8C09_FFFC, 32'h5,         3};

    // Reset state, checked before release.
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 2'd0, 32'h0, 32'h0);
    model_reset();
    #11;
    check_all("reset");
    check("reset.pc_w",  pc_w,  RESET_PC_W);
    check("reset.adr_w", adr_w, RESET_PC_W);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      set_in(vecs[i].pw, vecs[i].br, vecs[i].z, vecs[i].ir, 1'b0, vecs[i].src,
             vecs[i].alu, vecs[i].rdat);
      step();
      check($sformatf("vec%0d.pc", i),      pc,      vecs[i].exp_pc);
      check($sformatf("vec%0d.instr", i),   instr,   vecs[i].exp_instr);
      check($sformatf("vec%0d.aluout", i),  aluout,  vecs[i].exp_aluout);
      check($sformatf("vec%0d.retired", i), retired, vecs[i].exp_ret);
      check($sformatf("vec%0d.op", i),      {26'b0, op}, {26'b0, vecs[i].exp_instr[31:26]});
      check($sformatf("vec%0d.rt", i),      {27'b0, rt}, {27'b0, vecs[i].exp_instr[20:16]});
      check($sformatf("vec%0d.signimm", i), signimm,
            {{16{vecs[i].exp_instr[15]}}, vecs[i].exp_instr[15:0]});
    end
    check("first_fetch_op_is_addi_ir_now_lw", {26'b0, op}, {26'b0, 6'h23});

    // iord: adr follows the select in the same cycle.
    set_in(0, 0, 0, 0, 0, 2'd0, 32'h80, 32'h0);
    step();
    iord = 1'b1; #1;
    check("iord1.adr", adr, 32'h80);
    iord = 1'b0; #1;
    check("iord0.adr", adr, 32'h1000_0040);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
             $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
             $urandom, $urandom);
      step();
      check_all($sformatf("rnd%0d", i));
    end

    // Async reset between edges clears everything before the next edge.
    @(negedge clk); #1;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    check("async_rst.pc_w", pc_w, RESET_PC_W);
    @(negedge clk);
    reset = 1'b0;
    set_in(1, 0, 0, 1, 0, 2'd0, 32'h4, 32'h2008_0005);
    #1;
    check("post_rst.adr", adr, 32'h0);
    step();
    check_all("post_rst_fetch");

    // Counter wrap on the 4-bit instance: 15 -> 0 on the 16th IR load.
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    reset = 1'b0;
    set_in(0, 0, 0, 1, 0, 2'd0, 32'h0, 32'h1234_5678);
    for (int i = 0; i < 15; i++) step();
    check("wrap.all_ones", {28'b0, retired_w}, 32'hF);
    step();
    check("wrap.zero", {28'b0, retired_w}, 32'h0);
    check("wrap.wide", retired, 32'd16);
    irwrite = 1'b0;
    step();
    check_all("wrap.hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
